// File: rtl/regfile_pkg.sv
// Shared register-file constants: default geometry, the "no register" address and special registers.
// Also defines the per-register action type used by the pending-write scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NREG   = 16;
  localparam int DEF_NRD    = 2;

  // Decode also uses this address to mean "no source / no destination".
  localparam int ZERO_REG   = 15;

  localparam int SP = 8;
  localparam int T  = 9;
  localparam int IH = 10;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_SET,
    PEND_CLEAR,
    PEND_DROP
  } pend_act_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bundle for regfile_sb: read ports, writeback, issue reservation, flush and pending count.
// master = decode/writeback driver, slave = register file.
interface regfile_sb_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int NREG   = regfile_pkg::DEF_NREG,
  parameter int NRD    = regfile_pkg::DEF_NRD
);
  localparam int CNT_W = $clog2(NREG + 1);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;

  logic                  iss_valid;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  iss_ready;

  logic                  flush;
  logic [CNT_W-1:0]      pend_cnt;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, iss_valid, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, pend_cnt
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, iss_valid, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, pend_cnt
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on accepted issue, cleared by writeback, dropped by flush.
// iss_ready is combinational (no dependence on iss_valid); pend/pend_cnt update one edge after the request.
module pending_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREG     = DEF_NREG,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  parameter int CNT_W    = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [NREG-1:0]   pend,
  output logic              iss_ready,
  output logic [CNT_W-1:0]  pend_cnt
);

  logic [NREG-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_fire;
  logic             iss_fire;
  logic             wb_hit_iss;
  pend_act_e        act;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) != ZERO_REG) && (32'(a) < NREG);
  endfunction

  assign wb_fire    = wb_en && addr_ok(wb_addr);
  // A write retiring this cycle frees its register for an immediate re-reservation.
  assign wb_hit_iss = wb_en && (wb_addr == iss_addr);
  assign iss_ready  = !addr_ok(iss_addr) || !pend_q[iss_addr] || wb_hit_iss;
  assign iss_fire   = iss_valid && iss_ready && addr_ok(iss_addr);

  always_comb begin
    pend_d = pend_q;
    cnt_d  = '0;
    act    = PEND_HOLD;
    for (int i = 0; i < NREG; i++) begin
      act = PEND_HOLD;
      if (flush) begin
        act = PEND_DROP;
      end else if (iss_fire && (32'(iss_addr) == i)) begin
        act = PEND_SET;
      end else if (wb_fire && (32'(wb_addr) == i)) begin
        act = PEND_CLEAR;
      end
      case (act)
        PEND_SET:              pend_d[i] = 1'b1;
        PEND_CLEAR, PEND_DROP: pend_d[i] = 1'b0;
        default:               pend_d[i] = pend_q[i];
      endcase
      cnt_d = cnt_d + CNT_W'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// General register file with same-cycle writeback bypass and a pending-write scoreboard for decode hazards.
// Reads 0-cycle combinational, writes land 1 edge later; decode stalls itself via rd_busy / iss_ready.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic       clk,
  input  logic       rst,
  regfile_sb_if.slave bus
);

  localparam int CNT_W = $clog2(NREG + 1);

  logic [DATA_W-1:0]          mem_q [NREG];
  logic [DATA_W-1:0]          mem_d [NREG];
  logic [NREG-1:0]            pend;
  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;
  logic                       wb_fire;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) != ZERO_REG) && (32'(a) < NREG);
  endfunction

  assign rd_addr     = bus.rd_addr;
  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
  assign wb_fire     = bus.wb_en && addr_ok(bus.wb_addr);

  pending_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (bus.wb_en),
    .wb_addr   (bus.wb_addr),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .flush     (bus.flush),
    .pend      (pend),
    .iss_ready (bus.iss_ready),
    .pend_cnt  (bus.pend_cnt)
  );

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wb_fire) begin
      mem_d[bus.wb_addr] = bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // A matching writeback is the newest value, so it also hides the stale pending bit.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!addr_ok(rd_addr[i])) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end else if (bus.wb_en && (bus.wb_addr == rd_addr[i])) begin
        rd_data[i] = bus.wb_data;
        rd_busy[i] = 1'b0;
      end else begin
        rd_data[i] = mem_q[rd_addr[i]];
        rd_busy[i] = pend[rd_addr[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed hazard scenarios followed by randomized traffic.
// The reference is a plain array of register values plus a pending flag per register.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int NR = DEF_NREG;
  localparam int NP = DEF_NRD;

  logic clk;
  logic rst;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR), .NRD(NP)) bus ();

  regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NREG     (NR),
    .NRD      (NP),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ref_reg  [NR];
  bit            ref_pend [NR];
  int            n_checks;
  int            n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ok(input int a);
    return (a != ZERO_REG) && (a < NR);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (!ok(a)) return '0;
    if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
    return ref_reg[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (!ok(a)) return 1'b0;
    if (bus.wb_en && int'(bus.wb_addr) == a) return 1'b0;
    return ref_pend[a];
  endfunction

  function automatic bit exp_ready();
    int a;
    a = int'(bus.iss_addr);
    if (!ok(a)) return 1'b1;
    return !ref_pend[a] || (bus.wb_en && int'(bus.wb_addr) == a);
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) n += int'(ref_pend[i]);
    return n;
  endfunction

  function automatic logic [DW-1:0] rd_port(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  // Rising-edge state update of the reference, using the inputs held across the edge.
  task automatic model_clock();
    bit rdy;
    int wa;
    int ia;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        ref_reg[i]  = '0;
        ref_pend[i] = 1'b0;
      end
    end else begin
      rdy = exp_ready();
      wa  = int'(bus.wb_addr);
      ia  = int'(bus.iss_addr);
      if (bus.wb_en && ok(wa)) begin
        ref_reg[wa]  = bus.wb_data;
        ref_pend[wa] = 1'b0;
      end
      if (bus.flush) begin
        for (int i = 0; i < NR; i++) ref_pend[i] = 1'b0;
      end else if (bus.iss_valid && rdy && ok(ia)) begin
        ref_pend[ia] = 1'b1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    for (int p = 0; p < NP; p++) begin
      int a;
      a = int'(bus.rd_addr[p*AW +: AW]);
      chk({tag, "_rd_data"}, 32'(rd_port(p)), 32'(exp_data(a)));
      chk({tag, "_rd_busy"}, 32'(bus.rd_busy[p]), 32'(exp_busy(a)));
    end
    chk({tag, "_iss_ready"}, 32'(bus.iss_ready), 32'(exp_ready()));
    chk({tag, "_pend_cnt"}, 32'(bus.pend_cnt), 32'(exp_cnt()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic do_wb(input int a, input logic [DW-1:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = AW'(a);
    bus.wb_data = d;
  endtask

  task automatic do_iss(input int a);
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(a);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NR; i++) begin
      ref_reg[i]  = '0;
      ref_pend[i] = 1'b0;
    end

    rst = 1'b1;
    idle();
    set_rd(3, SP);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    settle();
    compare_model("reset");
    chk("reset_rd0", 32'(rd_port(0)), 32'h0);
    chk("reset_rd1", 32'(rd_port(1)), 32'h0);
    chk("reset_busy", 32'(bus.rd_busy), 32'h0);
    chk("reset_ready", 32'(bus.iss_ready), 32'h1);
    chk("reset_cnt", 32'(bus.pend_cnt), 32'h0);
    tick();

    // Writeback bypass, then array read
    do_wb(5, 16'h1234);
    set_rd(5, T);
    settle();
    compare_model("byp");
    chk("byp_rd0", 32'(rd_port(0)), 32'h1234);
    tick();
    idle();
    settle();
    chk("arr_rd0", 32'(rd_port(0)), 32'h1234);
    tick();

    // Reservation, WAW stall, resolving writeback
    do_iss(2);
    settle();
    compare_model("iss2");
    tick();
    idle();
    set_rd(2, 2);
    do_iss(2);
    settle();
    compare_model("waw");
    chk("waw_busy", 32'(bus.rd_busy), 32'h3);
    chk("waw_cnt", 32'(bus.pend_cnt), 32'h1);
    chk("waw_ready", 32'(bus.iss_ready), 32'h0);
    tick();
    idle();
    do_wb(2, 16'h00FF);
    settle();
    chk("wb2_busy", 32'(bus.rd_busy[0]), 32'h0);
    chk("wb2_rd0", 32'(rd_port(0)), 32'h00FF);
    tick();
    idle();
    settle();
    chk("wb2_cnt", 32'(bus.pend_cnt), 32'h0);
    tick();

    // Same-cycle clear and set on r4: set wins, data still written
    do_iss(4);
    settle();
    tick();
    idle();
    do_wb(4, 16'h4444);
    do_iss(4);
    settle();
    compare_model("setclr");
    chk("setclr_ready", 32'(bus.iss_ready), 32'h1);
    tick();
    idle();
    set_rd(4, 4);
    settle();
    chk("setclr_busy", 32'(bus.rd_busy[0]), 32'h1);
    chk("setclr_rd0", 32'(rd_port(0)), 32'h4444);
    chk("setclr_cnt", 32'(bus.pend_cnt), 32'h1);
    do_wb(4, 16'h4445);
    tick();
    idle();

    // Flush beats issue, writeback data survives
    do_iss(1); settle(); tick();
    do_iss(3); settle(); tick();
    do_iss(6); settle(); tick();
    idle();
    settle();
    chk("fl_cnt3", 32'(bus.pend_cnt), 32'h3);
    tick();
    bus.flush = 1'b1;
    do_iss(7);
    do_wb(3, 16'hBEEF);
    settle();
    compare_model("flush");
    tick();
    idle();
    set_rd(3, 7);
    settle();
    compare_model("postfl");
    chk("fl_cnt0", 32'(bus.pend_cnt), 32'h0);
    chk("fl_rd0", 32'(rd_port(0)), 32'hBEEF);
    chk("fl_busy7", 32'(bus.rd_busy[1]), 32'h0);
    tick();

    // The "no register" address ignores writes and reservations
    do_wb(ZERO_REG, 16'hFFFF);
    do_iss(ZERO_REG);
    settle();
    chk("zr_ready", 32'(bus.iss_ready), 32'h1);
    tick();
    idle();
    set_rd(ZERO_REG, ZERO_REG);
    settle();
    chk("zr_rd0", 32'(rd_port(0)), 32'h0);
    chk("zr_rd1", 32'(rd_port(1)), 32'h0);
    chk("zr_busy", 32'(bus.rd_busy), 32'h0);
    chk("zr_cnt", 32'(bus.pend_cnt), 32'h0);
    tick();
    set_rd(T, IH);
    settle();
    compare_model("special");
    tick();

    // Randomized traffic including occasional flush and mid-run reset
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(63) == 0);
      bus.wb_en     = 1'($urandom_range(1));
      bus.wb_addr   = AW'($urandom_range(NR - 1));
      bus.wb_data   = DW'($urandom);
      bus.iss_valid = 1'($urandom_range(1));
      bus.iss_addr  = AW'($urandom_range(NR - 1));
      bus.flush     = ($urandom_range(15) == 0);
      set_rd(int'($urandom_range(NR - 1)), int'($urandom_range(NR - 1)));
      settle();
      compare_model("rand");
      tick();
    end
    rst = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
